// File: rtl/gain_curve_pingpong_ram_pkg.sv
// Shared types and constants for the ping-pong gain-curve RAM.
package peq_ram_pkg;

  typedef enum logic [1:0] {
    RST_FILL = 2'd0,
    IDLE     = 2'd1,
    FILL     = 2'd2
  } state_t;

  localparam logic BANK0      = 1'b0;
  localparam int   DROP_CNT_W = 16;

endpackage

// File: rtl/gain_curve_pingpong_ram_sdp_bram.sv
// Single-clock simple dual-port block RAM: one write port, one registered read port.
module sdp_bram #(
  parameter int LOGSIZE = 14,
  parameter int WIDTH   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [LOGSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]   din,
  input  logic               re,
  input  logic [LOGSIZE-1:0] raddr,
  output logic [WIDTH-1:0]   dout
);

  logic [WIDTH-1:0] mem [2**LOGSIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  // Output register reset maps onto the block RAM's output-latch reset.
  always_ff @(posedge clk) begin
    if (reset)   dout <= '0;
    else if (re) dout <= mem[raddr];
  end

endmodule

// File: rtl/gain_curve_pingpong_ram.sv
// Double-buffered gain-curve store with frame-aligned bank swap and fill engine.
// Optional drop counter port enabled by defining GAIN_RAM_DROP_CNT_EN.
module gain_curve_pingpong_ram
  import peq_ram_pkg::*;
#(
  parameter int               LOGSIZE    = 13,
  parameter int               WIDTH      = 12,
  parameter logic [WIDTH-1:0] INIT_VALUE = 12'd1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LOGSIZE-1:0] wr_addr,
  input  logic [WIDTH-1:0]   wr_din,
  input  logic               wr_we,
  input  logic [LOGSIZE-1:0] rd_addr,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_dout,
  output logic               rd_valid,
  input  logic               swap_req,
  input  logic               frame_start,
  output logic               swap_pending,
  output logic               active_bank,
  input  logic               fill_req,
  output logic               busy
`ifdef GAIN_RAM_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] dropped_wr_cnt
`endif
);

  // Handshake: rd_en is a request with no back-pressure; rd_valid marks the
  // one-cycle-later rd_dout. Writes have no ready: wr_we outside IDLE or while
  // a swap is pending is discarded.

  state_t             state, state_next;
  logic [LOGSIZE:0]   fill_addr, fill_addr_next;
  logic               swap_now;
  logic               rd_bank;
  logic               user_wr_ok;
  logic               mem_we;
  logic [LOGSIZE:0]   mem_waddr;
  logic [WIDTH-1:0]   mem_din;
  logic               mem_re;

  assign busy       = (state != IDLE);
  assign swap_now   = frame_start & (swap_pending | swap_req) & ~busy;
  // The first read of a new frame must already see the incoming curve.
  assign rd_bank    = swap_now ? ~active_bank : active_bank;
  assign user_wr_ok = (state == IDLE) & ~swap_pending;
  assign mem_re     = rd_en & (state != RST_FILL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RST_FILL;
      fill_addr <= '0;
    end else begin
      state     <= state_next;
      fill_addr <= fill_addr_next;
    end
  end

  always_comb begin
    state_next     = state;
    fill_addr_next = fill_addr;
    case (state)
      RST_FILL: begin
        fill_addr_next = fill_addr + 1'b1;
        if (fill_addr == '1) begin
          state_next     = IDLE;
          fill_addr_next = '0;
        end
      end
      IDLE: begin
        if (fill_req && !swap_pending) begin
          state_next     = FILL;
          fill_addr_next = '0;
        end
      end
      FILL: begin
        fill_addr_next = fill_addr + 1'b1;
        if (fill_addr[LOGSIZE-1:0] == '1) begin
          state_next     = IDLE;
          fill_addr_next = '0;
        end
      end
      default: begin
        state_next     = RST_FILL;
        fill_addr_next = '0;
      end
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {~active_bank, wr_addr};
    mem_din   = wr_din;
    case (state)
      RST_FILL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_addr;
        mem_din   = INIT_VALUE;
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_waddr = {~active_bank, fill_addr[LOGSIZE-1:0]};
        mem_din   = INIT_VALUE;
      end
      default: mem_we = wr_we & user_wr_ok;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_bank  <= BANK0;
      swap_pending <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= mem_re;
      if (swap_now) begin
        active_bank  <= ~active_bank;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  sdp_bram #(
    .LOGSIZE (LOGSIZE + 1),
    .WIDTH   (WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (mem_waddr),
    .din   (mem_din),
    .re    (mem_re),
    .raddr ({rd_bank, rd_addr}),
    .dout  (rd_dout)
  );

`ifdef GAIN_RAM_DROP_CNT_EN
  logic drop;
  assign drop = wr_we & ~user_wr_ok;

  always_ff @(posedge clk) begin
    if (reset)                              dropped_wr_cnt <= '0;
    else if (drop && dropped_wr_cnt != '1)  dropped_wr_cnt <= dropped_wr_cnt + 1'b1;
  end
`else
  // Dropped writes are discarded without being counted.
`endif

endmodule

// File: tb/tb_gain_curve_pingpong_ram.sv
// Directed bench for gain_curve_pingpong_ram (LOGSIZE=4) with a read-data scoreboard.
module tb_gain_curve_pingpong_ram;

  localparam int LOGSIZE = 4;
  localparam int WIDTH   = 12;
  localparam logic [WIDTH-1:0] UNITY = 12'd1024;

  logic               clk = 1'b0;
  logic               reset;
  logic [LOGSIZE-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_din;
  logic               wr_we;
  logic [LOGSIZE-1:0] rd_addr;
  logic               rd_en;
  logic [WIDTH-1:0]   rd_dout;
  logic               rd_valid;
  logic               swap_req;
  logic               frame_start;
  logic               swap_pending;
  logic               active_bank;
  logic               fill_req;
  logic               busy;
`ifdef GAIN_RAM_DROP_CNT_EN
  logic [15:0]        dropped_wr_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  gain_curve_pingpong_ram #(
    .LOGSIZE    (LOGSIZE),
    .WIDTH      (WIDTH),
    .INIT_VALUE (UNITY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_addr      (wr_addr),
    .wr_din       (wr_din),
    .wr_we        (wr_we),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .rd_dout      (rd_dout),
    .rd_valid     (rd_valid),
    .swap_req     (swap_req),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .active_bank  (active_bank),
    .fill_req     (fill_req),
    .busy         (busy)
`ifdef GAIN_RAM_DROP_CNT_EN
    ,
    .dropped_wr_cnt (dropped_wr_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard / checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("rd_dout", 32'(rd_dout), 32'(e));
      end
    end
  end

  // Driver tasks (inputs change 1 time unit after the active edge)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_one(input logic [LOGSIZE-1:0] a, input logic [WIDTH-1:0] e);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic write_one(input logic [LOGSIZE-1:0] a, input logic [WIDTH-1:0] d);
    wr_we   = 1'b1;
    wr_addr = a;
    wr_din  = d;
    tick(1);
    wr_we = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    tick(1);
    swap_req = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_addr = '0; wr_din = '0; wr_we = 1'b0;
    rd_addr = '0; rd_en = 1'b0; swap_req = 1'b0; frame_start = 1'b0; fill_req = 1'b0;

    // Reset state and power-on fill
    tick(2);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_active_bank", 32'(active_bank), 32'd0);
    check("reset_swap_pending", 32'(swap_pending), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_dout", 32'(rd_dout), 32'd0);
    reset = 1'b0;
    count_busy(n);
    check("rst_fill_cycles", 32'(n), 32'd32);
    for (int i = 0; i < 16; i++) read_one(LOGSIZE'(i), UNITY);
    tick(1);

    // Shadow write becomes visible only after a frame-aligned swap
    write_one(4'd3, 12'h0AB);
    read_one(4'd3, UNITY);
    pulse_swap();
    check("swap_pending_set", 32'(swap_pending), 32'd1);
    tick(4);
    frame_start = 1'b1;
    read_one(4'd3, 12'h0AB);
    frame_start = 1'b0;
    check("active_after_swap", 32'(active_bank), 32'd1);
    check("pending_cleared", 32'(swap_pending), 32'd0);

    // swap_req together with frame_start swaps at once
    swap_req = 1'b1; frame_start = 1'b1;
    tick(1);
    swap_req = 1'b0; frame_start = 1'b0;
    check("same_cycle_pending", 32'(swap_pending), 32'd0);
    check("same_cycle_active", 32'(active_bank), 32'd0);
    read_one(4'd3, UNITY);

    // Write while a swap is pending is dropped
    pulse_swap();
    write_one(4'd2, 12'h123);
`ifdef GAIN_RAM_DROP_CNT_EN
    check("dropped_wr_cnt", 32'(dropped_wr_cnt), 32'd1);
`endif
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("active_after_swap2", 32'(active_bank), 32'd1);
    read_one(4'd2, UNITY);
    read_one(4'd3, 12'h0AB);

    // Fill: swap latched while busy, frame_start ignored until idle
    write_one(4'd5, 12'h777);
    fill_req = 1'b1;
    tick(1);
    fill_req = 1'b0;
    check("fill_busy", 32'(busy), 32'd1);
    tick(2);
    pulse_swap();
    tick(2);
    frame_start = 1'b1;
    read_one(4'd5, UNITY);
    frame_start = 1'b0;
    check("no_swap_while_busy", 32'(active_bank), 32'd1);
    check("pending_while_busy", 32'(swap_pending), 32'd1);
    count_busy(n);
    check("fill_cycles", 32'(n + 7), 32'd17);
    frame_start = 1'b1;
    read_one(4'd5, UNITY);
    frame_start = 1'b0;
    check("swap_after_fill", 32'(active_bank), 32'd0);
    for (int i = 0; i < 16; i++) read_one(LOGSIZE'(i), UNITY);

    // Reset in the middle of FILL restarts the full power-on fill
    swap_req = 1'b1; frame_start = 1'b1;
    tick(1);
    swap_req = 1'b0; frame_start = 1'b0;
    check("pre_reset_active", 32'(active_bank), 32'd1);
    fill_req = 1'b1;
    tick(1);
    fill_req = 1'b0;
    tick(4);
    pulse_swap();
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midfill_reset_active", 32'(active_bank), 32'd0);
    check("midfill_reset_pending", 32'(swap_pending), 32'd0);
    count_busy(n);
    check("midfill_reset_cycles", 32'(n), 32'd32);
    read_one(4'd3, UNITY);
    read_one(4'd2, UNITY);

    // Final report
    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
